// File: rtl/sdr_wb_arbiter.sv
// Two-master Wishbone arbiter in front of an SDRAM controller slave port.
// Ties go to the master not served last; a burst keeps its grant until end-of-burst.
module sdr_wb_arbiter #(
    parameter int adr_size = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         m0_dat_i,
    input  logic [adr_size-1:0] m0_adr_i,
    input  logic [3:0]          m0_sel_i,
    input  logic [2:0]          m0_cti_i,
    input  logic [1:0]          m0_bte_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic [31:0]         m0_dat_o,
    output logic                m0_ack_o,
    input  logic [31:0]         m1_dat_i,
    input  logic [adr_size-1:0] m1_adr_i,
    input  logic [3:0]          m1_sel_i,
    input  logic [2:0]          m1_cti_i,
    input  logic [1:0]          m1_bte_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic [31:0]         m1_dat_o,
    output logic                m1_ack_o,
    output logic [31:0]         s_dat_o,
    output logic [adr_size-1:0] s_adr_o,
    output logic [3:0]          s_sel_o,
    output logic [2:0]          s_cti_o,
    output logic [1:0]          s_bte_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [31:0]         s_dat_i,
    input  logic                s_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;   // 1: m1 was served last

    function automatic logic cycle_done(input logic [2:0] cti);
        return (cti == 3'b000) || (cti == 3'b111);
    endfunction

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || (s_ack_i && cycle_done(m0_cti_i))) state_d = IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i || (s_ack_i && cycle_done(m1_cti_i))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload follows m0 unless m1 holds the grant; handshakes are gated by the grant.
    always_comb begin
        s_dat_o  = m0_dat_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
            end
            GNT1: begin
                s_dat_o  = m1_dat_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// Directed scenarios plus a randomized two-master run against a word memory,
// with grant ownership predicted from the arbitration rules.
module tb_sdr_wb_arbiter;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic          m0_ack_o, m1_ack_o, s_we_o, s_cyc_o, s_stb_o, s_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    sdr_wb_arbiter #(.adr_size(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
        .m0_bte_i(m0_bte_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
        .m1_bte_i(m1_bte_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_masters();
        {m0_dat_i, m0_adr_i, m0_sel_i, m0_cti_i, m0_bte_i, m0_we_i, m0_cyc_i, m0_stb_i} = '0;
        {m1_dat_i, m1_adr_i, m1_sel_i, m1_cti_i, m1_bte_i, m1_we_i, m1_cyc_i, m1_stb_i} = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic test_reset();
        idle_masters();
        rst = 1'b1;
        {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = 5'b11111;
        repeat (2) next_cycle();
        settle();
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_s_stb: got %b want 0", s_stb_o); end
        n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_m0_ack: got %b want 0", m0_ack_o); end
        n_cmp++; if (m1_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_m1_ack: got %b want 0", m1_ack_o); end
        idle_masters();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_tie();
        next_cycle();
        m0_adr_i = 24'h000100; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 24'h800200; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        settle();
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL tie_idle_cyc: got %b want 0", s_cyc_o); end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            settle();
            n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL tie_gnt0_cyc: got %b want 1", s_cyc_o); end
            n_cmp++; if (s_adr_o !== 24'h000100) begin n_bad++; $display("FAIL tie_gnt0_adr: got %h want 000100", s_adr_o); end
            n_cmp++; if (m1_ack_o !== 1'b0) begin n_bad++; $display("FAIL tie_m1_ack: got %b want 0", m1_ack_o); end
        end
    endtask

    task automatic test_handover();
        next_cycle();
        m0_we_i = 1'b1; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hA;
        s_ack_i = 1'b1; s_dat_i = 32'h12345678;
        settle();
        n_cmp++; if (m0_ack_o !== 1'b1) begin n_bad++; $display("FAIL ho_m0_ack: got %b want 1", m0_ack_o); end
        n_cmp++; if (m1_ack_o !== 1'b0) begin n_bad++; $display("FAIL ho_m1_ack: got %b want 0", m1_ack_o); end
        n_cmp++; if ({s_we_o, s_sel_o, s_dat_o} !== {1'b1, 4'hA, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL ho_write_payload: got %b/%h/%h want 1/a/deadbeef", s_we_o, s_sel_o, s_dat_o); end
        n_cmp++; if ({m0_dat_o, m1_dat_o} !== {2{32'h12345678}}) begin
            n_bad++; $display("FAIL ho_rdata: got %h/%h want 12345678", m0_dat_o, m1_dat_o); end
        next_cycle();
        s_ack_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = 24'h000104;
        settle();
        n_cmp++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_bad++; $display("FAIL ho_dead_cycle: got %b want 00", {s_cyc_o, s_stb_o}); end
        next_cycle();
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if (s_adr_o !== 24'h800200) begin n_bad++; $display("FAIL ho_gnt1_adr: got %h want 800200", s_adr_o); end
        n_cmp++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin n_bad++; $display("FAIL ho_gnt1_ack: got %b want 01", {m0_ack_o, m1_ack_o}); end
        next_cycle();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        settle();
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL ho_dead2: got %b want 0", s_cyc_o); end
        next_cycle();
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if ({s_adr_o, m0_ack_o} !== {24'h000104, 1'b1}) begin
            n_bad++; $display("FAIL ho_regrant_m0: got %h/%b want 000104/1", s_adr_o, m0_ack_o); end
        next_cycle();
        idle_masters();
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin n_bad++; $display("FAIL ho_stray_ack: got %b want 00", {m0_ack_o, m1_ack_o}); end
        s_ack_i = 1'b0;
    endtask

    task automatic test_burst_hold();
        logic [23:0] base;
        base = 24'h800010;
        next_cycle();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_bte_i = 2'b01; m1_cti_i = 3'b010; m1_adr_i = base;
        settle();
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                next_cycle();
                s_ack_i = 1'b0;
                settle();
                n_cmp++; if ({s_cyc_o, m1_ack_o, m0_ack_o} !== 3'b100) begin
                    n_bad++; $display("FAIL burst_wait: got %b want 100", {s_cyc_o, m1_ack_o, m0_ack_o}); end
            end
            next_cycle();
            m1_adr_i = base | 24'(k & 3);
            m1_cti_i = (k == 7) ? 3'b111 : 3'b010;
            if (k == 2) begin
                m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h000200; m0_cti_i = 3'b000;
            end
            s_ack_i = 1'b1;
            s_dat_i = 32'hB0000000 + 32'(k);
            settle();
            n_cmp++; if ({s_cyc_o, s_adr_o, s_cti_o, s_bte_o} !== {1'b1, m1_adr_i, m1_cti_i, 2'b01}) begin
                n_bad++; $display("FAIL burst_beat%0d_bus: got %b/%h/%b/%b", k, s_cyc_o, s_adr_o, s_cti_o, s_bte_o); end
            n_cmp++; if ({m1_ack_o, m0_ack_o, m1_dat_o} !== {2'b10, 32'hB0000000 + 32'(k)}) begin
                n_bad++; $display("FAIL burst_beat%0d_ack: got %b%b/%h want 10/%h", k, m1_ack_o, m0_ack_o, m1_dat_o, 32'hB0000000 + 32'(k)); end
        end
        next_cycle();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'b000;
        settle();
        n_cmp++; if ({s_cyc_o, m0_ack_o} !== 2'b00) begin n_bad++; $display("FAIL burst_dead: got %b want 00", {s_cyc_o, m0_ack_o}); end
        next_cycle();
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if ({s_cyc_o, s_adr_o, m0_ack_o} !== {1'b1, 24'h000200, 1'b1}) begin
            n_bad++; $display("FAIL burst_m0_after: got %b/%h/%b want 1/000200/1", s_cyc_o, s_adr_o, m0_ack_o); end
        next_cycle();
        idle_masters();
    endtask

    task automatic test_cyc_drop();
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010; m0_adr_i = 24'h000300;
        settle();
        next_cycle();
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if (m0_ack_o !== 1'b1) begin n_bad++; $display("FAIL drop_beat_ack: got %b want 1", m0_ack_o); end
        next_cycle();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_bte_i = 2'b01; m1_adr_i = 24'h800400;
        settle();
        n_cmp++; if ({s_cyc_o, m1_ack_o} !== 2'b00) begin n_bad++; $display("FAIL drop_cyc_follow: got %b want 00", {s_cyc_o, m1_ack_o}); end
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000; m0_adr_i = 24'h000304;
        s_ack_i = 1'b1;
        settle();
        n_cmp++; if ({s_cyc_o, m0_ack_o, m1_ack_o} !== 3'b000) begin
            n_bad++; $display("FAIL drop_idle_stray: got %b want 000", {s_cyc_o, m0_ack_o, m1_ack_o}); end
        next_cycle();
        s_ack_i = 1'b0;
        settle();
        n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 24'h800400}) begin
            n_bad++; $display("FAIL drop_tie_m1: got %b/%h want 1/800400", s_cyc_o, s_adr_o); end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (m1_ack_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_ack: got %b want 1", m1_ack_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({s_cyc_o, s_stb_o, m1_ack_o} !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_async: got %b want 000", {s_cyc_o, s_stb_o, m1_ack_o}); end
        next_cycle();
        rst = 1'b0; s_ack_i = 1'b0;
        settle();
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want 0", s_cyc_o); end
        next_cycle();
        settle();
        n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 24'h000304}) begin
            n_bad++; $display("FAIL rstmid_gnt0: got %b/%h want 1/000304", s_cyc_o, s_adr_o); end
        idle_masters();
        repeat (2) next_cycle();
    endtask

    // Randomized traffic: state of each master's pending transaction and memories
    bit          act [2], we [2], burst [2];
    int          beats [2], idx [2], done [2];
    logic [31:0] wdat [2];
    logic [3:0]  wsel [2];
    logic [31:0] shadow [2][16];
    logic [31:0] smem [32];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [23:0] mk_adr(input int m);
        return {(m == 1), 19'd0, 4'(idx[m])};
    endfunction

    function automatic logic [2:0] mk_cti(input int m);
        if (!burst[m]) return 3'b000;
        return (beats[m] == 1) ? 3'b111 : 3'b010;
    endfunction

    task automatic start_maybe(input int m);
        if (!act[m] && $urandom_range(0, 2) == 0) begin
            act[m]   = 1'b1;
            we[m]    = 1'($urandom_range(0, 1));
            burst[m] = 1'($urandom_range(0, 1));
            beats[m] = burst[m] ? int'($urandom_range(2, 8)) : 1;
            idx[m]   = int'($urandom_range(0, 15));
            wdat[m]  = $urandom();
            wsel[m]  = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic test_random();
        int  owner;
        bit  last, allow, acked;
        int  prev_obs, obs, budget;
        logic [31:0] rd;
        for (int m = 0; m < 2; m++) begin
            act[m] = 0; done[m] = 0;
            for (int i = 0; i < 16; i++) begin
                shadow[m][i]    = 32'hA5000000 ^ (32'(m) << 12) ^ 32'(i * 32'h00010203);
                smem[m * 16 + i] = shadow[m][i];
            end
        end
        idle_masters();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        owner = 0; last = 1'b1; prev_obs = 0; allow = 1'b1; budget = 0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            if (cyc == 3000) allow = 1'b0;
            if (!allow && !act[0] && !act[1]) break;
            budget = cyc;
            next_cycle();
            m0_cyc_i = act[0]; m0_stb_i = act[0]; m0_we_i = we[0]; m0_adr_i = mk_adr(0);
            m0_dat_i = wdat[0]; m0_sel_i = wsel[0]; m0_cti_i = mk_cti(0); m0_bte_i = 2'b00;
            m1_cyc_i = act[1]; m1_stb_i = act[1]; m1_we_i = we[1]; m1_adr_i = mk_adr(1);
            m1_dat_i = wdat[1]; m1_sel_i = wsel[1]; m1_cti_i = mk_cti(1); m1_bte_i = 2'b00;
            #1;
            if (s_cyc_o && s_stb_o) begin
                s_ack_i = ($urandom_range(0, 3) != 0);
                s_dat_i = s_we_o ? $urandom() : smem[{s_adr_o[23], s_adr_o[3:0]}];
            end else begin
                s_ack_i = ($urandom_range(0, 9) == 0);
                s_dat_i = $urandom();
            end
            #1;
            n_cmp++; if ({m0_ack_o, m1_ack_o} !== {(owner == 1) && s_ack_i, (owner == 2) && s_ack_i}) begin
                n_bad++; $display("FAIL rnd_ack c%0d: got %b%b want owner %0d ack %b", cyc, m0_ack_o, m1_ack_o, owner, s_ack_i); end
            n_cmp++; if (s_cyc_o !== ((owner == 1) ? m0_cyc_i : (owner == 2) ? m1_cyc_i : 1'b0)) begin
                n_bad++; $display("FAIL rnd_cyc c%0d: got %b owner %0d", cyc, s_cyc_o, owner); end
            if (m0_ack_o && m1_ack_o) begin
                n_cmp++; n_bad++; $display("FAIL rnd_dual_ack c%0d: got 11 want at most one", cyc);
            end
            obs = s_cyc_o ? (s_adr_o[23] ? 2 : 1) : 0;
            if (obs != 0 && prev_obs != 0) begin
                n_cmp++; if (obs != prev_obs) begin n_bad++; $display("FAIL rnd_no_dead c%0d: got %0d after %0d", cyc, obs, prev_obs); end
            end
            prev_obs = obs;
            if (s_ack_i && s_cyc_o && s_stb_o && s_we_o)
                smem[{s_adr_o[23], s_adr_o[3:0]}] = merge(smem[{s_adr_o[23], s_adr_o[3:0]}], s_dat_o, s_sel_o);
            for (int m = 0; m < 2; m++) begin
                acked = (m == 0) ? m0_ack_o : m1_ack_o;
                rd    = (m == 0) ? m0_dat_o : m1_dat_o;
                if (act[m] && acked) begin
                    if (we[m]) shadow[m][idx[m]] = merge(shadow[m][idx[m]], wdat[m], wsel[m]);
                    else begin
                        n_cmp++; if (rd !== shadow[m][idx[m]]) begin
                            n_bad++; $display("FAIL rnd_rdata m%0d c%0d: got %h want %h", m, cyc, rd, shadow[m][idx[m]]); end
                    end
                    beats[m]--;
                    idx[m]  = (idx[m] + 1) & 15;
                    wdat[m] = $urandom();
                    wsel[m] = 4'($urandom_range(1, 15));
                    if (beats[m] == 0) begin act[m] = 1'b0; done[m]++; end
                end
            end
            case (owner)
                0: begin
                    if (m0_cyc_i && m1_cyc_i) owner = last ? 1 : 2;
                    else if (m0_cyc_i) owner = 1;
                    else if (m1_cyc_i) owner = 2;
                    if (owner != 0) last = (owner == 2);
                end
                1: if (!m0_cyc_i || (s_ack_i && (m0_cti_i == 3'b000 || m0_cti_i == 3'b111))) owner = 0;
                default: if (!m1_cyc_i || (s_ack_i && (m1_cti_i == 3'b000 || m1_cti_i == 3'b111))) owner = 0;
            endcase
            if (allow) begin
                start_maybe(0);
                start_maybe(1);
            end
        end
        n_cmp++; if (act[0] || act[1]) begin
            n_bad++; $display("FAIL rnd_drain_timeout: got active %b%b after %0d cycles want 00", act[0], act[1], budget); end
        n_cmp++; if (done[0] == 0 || done[1] == 0) begin
            n_bad++; $display("FAIL rnd_progress: got done %0d/%0d want both nonzero", done[0], done[1]); end
        idle_masters();
        next_cycle();
    endtask

    initial begin
        idle_masters();
        test_reset();
        test_tie();
        test_handover();
        test_burst_hold();
        test_cyc_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
